cpu_step_sequencer: RTL

Multicycle control sequencer for the small accumulator/register-file processor. It owns its own step counter, decodes the instruction held in the IR, and drives every datapath enable, register address and ALU opcode for each step. It starts on a run/done handshake. It generalises the earlier fixed 10-bit, 4-register controller in three ways:
- parametrised data width and register count
- optional sign-extended immediates
- illegal-opcode detection

It sits between the top-level run logic and the datapath (register file, A register, ALU, G register, IR).

---
 rtl/cpu_step_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_step_sequencer.sv
// Multicycle control sequencer: decodes IR contents and drives datapath enables per step.
// Latency T0..done inclusive: LOAD/COPY/illegal 2, INV/FLP 3, binary/immediate 4 cycles.
// Flow control: run sampled only in IDLE and done cycles; run held high chains instructions.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   run               request to execute one instruction
//   instr             IR contents (stable from T1 through the done cycle)
//   ir_in, ext        IR load, external bus drive
//   imm_en, imm       immediate bus drive and extended immediate value
//   rin, rout         register write / read addresses
//   enw, enr          register file write / read enables
//   ain, gin, gout    A load, G load, G bus drive
//   alu_op            ALU function select
//   busy, done        not-IDLE flag, final-step pulse
//   illegal           pulse on an undefined FN
//   step              current step number (0 while IDLE)
module cpu_step_sequencer #(
  parameter int DATA_W     = 10,
  parameter int RA_W       = 2,
  parameter int SIGNED_IMM = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] instr,
  output logic              ir_in,
  output logic              ext,
  output logic              imm_en,
  output logic [DATA_W-1:0] imm,
  output logic [RA_W-1:0]   rin,
  output logic [RA_W-1:0]   rout,
  output logic              enw,
  output logic              enr,
  output logic              ain,
  output logic              gin,
  output logic              gout,
  output logic [3:0]        alu_op,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [1:0]        step
);

  localparam int IMM_W = RA_W + 4;

  localparam logic [3:0] FN_LOAD = 4'd0;
  localparam logic [3:0] FN_COPY = 4'd1;
  localparam logic [3:0] FN_ADD  = 4'd2;
  localparam logic [3:0] FN_SUB  = 4'd3;
  localparam logic [3:0] FN_INV  = 4'd4;
  localparam logic [3:0] FN_FLP  = 4'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              w_m;
  logic              w_s;
  logic [RA_W-1:0]   w_rx;
  logic [RA_W-1:0]   w_ry;
  logic [3:0]        w_fn;
  logic [DATA_W-1:0] w_imm_ext;
  logic              w_is_unary;
  logic              w_is_illegal;
  logic              w_unused;

  assign w_m  = instr[DATA_W-1];
  assign w_s  = instr[DATA_W-2];
  assign w_rx = instr[2*RA_W+3:RA_W+4];
  assign w_ry = instr[RA_W+3:4];
  assign w_fn = instr[3:0];

  // Reserved instruction bits are deliberately ignored.
  assign w_unused = ^instr;

  generate
    if (SIGNED_IMM != 0) begin : g_sext
      assign w_imm_ext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    end else begin : g_zext
      assign w_imm_ext = {{(DATA_W-IMM_W){1'b0}}, instr[IMM_W-1:0]};
    end
  endgenerate

  assign w_is_unary   = (w_fn == FN_INV) || (w_fn == FN_FLP);
  assign w_is_illegal = (w_fn >= 4'd12);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    ir_in   = 1'b0;
    ext     = 1'b0;
    imm_en  = 1'b0;
    imm     = '0;
    rin     = '0;
    rout    = '0;
    enw     = 1'b0;
    enr     = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    alu_op  = 4'd0;
    busy    = 1'b1;
    done    = 1'b0;
    illegal = 1'b0;
    step    = 2'd0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (run) w_next = S_T0;
      end

      S_T0: begin
        ir_in  = 1'b1;
        ext    = 1'b1;
        w_next = S_T1;
      end

      S_T1: begin
        step = 2'd1;
        if (w_m) begin
          // Immediate ops: first operand rx into A.
          rout   = w_rx;
          enr    = 1'b1;
          ain    = 1'b1;
          w_next = S_T2;
        end else if (w_fn == FN_LOAD) begin
          ext  = 1'b1;
          rin  = w_rx;
          enw  = 1'b1;
          done = 1'b1;
        end else if (w_fn == FN_COPY) begin
          rout = w_ry;
          enr  = 1'b1;
          rin  = w_rx;
          enw  = 1'b1;
          done = 1'b1;
        end else if (w_is_unary) begin
          rout   = w_ry;
          enr    = 1'b1;
          gin    = 1'b1;
          alu_op = w_fn;
          w_next = S_T2;
        end else if (w_is_illegal) begin
          // Terminate without touching the datapath.
          illegal = 1'b1;
          done    = 1'b1;
        end else begin
          rout   = w_rx;
          enr    = 1'b1;
          ain    = 1'b1;
          w_next = S_T2;
        end
      end

      S_T2: begin
        step = 2'd2;
        if (w_m) begin
          imm_en = 1'b1;
          imm    = w_imm_ext;
          gin    = 1'b1;
          alu_op = w_s ? FN_SUB : FN_ADD;
          w_next = S_T3;
        end else if (w_is_unary) begin
          gout = 1'b1;
          rin  = w_rx;
          enw  = 1'b1;
          done = 1'b1;
        end else begin
          rout   = w_ry;
          enr    = 1'b1;
          gin    = 1'b1;
          alu_op = w_fn;
          w_next = S_T3;
        end
      end

      S_T3: begin
        step = 2'd3;
        gout = 1'b1;
        rin  = w_rx;
        enw  = 1'b1;
        done = 1'b1;
      end

      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase

    // Every done cycle is also a handshake point for the next instruction.
    if (done) w_next = run ? S_T0 : S_IDLE;
  end

endmodule
